// File: rtl/mem_access_pkg.sv
// Shared opcode/state encodings and opcode predicates for the data-memory access sequencer.
package mem_access_pkg;

  localparam logic [7:0] SP_INIT_DEF     = 8'hFF;
  localparam logic [7:0] STACK_LIMIT_DEF = 8'hE0;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_LOAD  = 3'd1,
    OP_STORE = 3'd2,
    OP_PUSH  = 3'd3,
    OP_POP   = 3'd4,
    OP_CALL  = 3'd5,
    OP_RET   = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  function automatic logic op_writes_mem(op_e op);
    return (op == OP_STORE) || (op == OP_PUSH) || (op == OP_CALL);
  endfunction

  function automatic logic op_is_stack(op_e op);
    return (op == OP_PUSH) || (op == OP_POP) || (op == OP_CALL) || (op == OP_RET);
  endfunction

  function automatic logic op_reads_mem(op_e op);
    return (op == OP_LOAD) || (op == OP_POP) || (op == OP_RET);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake between the control unit (master) and the access sequencer (slave).
interface mem_access_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [7:0] req_addr;
  logic [7:0] req_data;
  logic [7:0] req_pc;
  logic       resp_valid;
  logic [7:0] resp_data;
  logic       resp_err;
  logic       pc_load;
  logic [7:0] pc_target;

  modport master (
    output req_valid, req_op, req_addr, req_data, req_pc,
    input  req_ready, resp_valid, resp_data, resp_err, pc_load, pc_target
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_data, req_pc,
    output req_ready, resp_valid, resp_data, resp_err, pc_load, pc_target
  );
endinterface

// File: rtl/mem_access_ctrl_sp_unit.sv
// Stack pointer register with increment/decrement and full/empty status.
// Bounds status is only produced when STACK_CHECK_EN is defined; otherwise full/empty read 0.
module mem_access_ctrl_sp_unit #(
  parameter logic [7:0] SP_INIT     = 8'hFF,
  parameter logic [7:0] STACK_LIMIT = 8'hE0
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [7:0] sp_o,
  output logic       full_o,
  output logic       empty_o
);

  logic [7:0] sp_q;
  logic       full_raw;
  logic       empty_raw;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sp_q <= SP_INIT;
    end else if (inc_i) begin
      sp_q <= sp_q + 8'd1;
    end else if (dec_i) begin
      sp_q <= sp_q - 8'd1;
    end
  end

  assign sp_o      = sp_q;
  assign full_raw  = (sp_q < STACK_LIMIT);
  assign empty_raw = (sp_q == SP_INIT);

`ifdef STACK_CHECK_EN
  assign full_o  = full_raw;
  assign empty_o = empty_raw;
`else
  logic unused_bounds;
  assign unused_bounds = full_raw | empty_raw;
  assign full_o  = 1'b0;
  assign empty_o = 1'b0;
`endif

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store/stack sequencer in front of the 256x8 data memory: IDLE -> ACCESS -> RESP.
// Optional STACK_CHECK_EN enables stack full/empty rejection and the sticky stack_ovf/stack_unf flags.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter logic [7:0] SP_INIT     = SP_INIT_DEF,
  parameter logic [7:0] STACK_LIMIT = STACK_LIMIT_DEF
) (
  input  logic             clk_i,
  input  logic             reset_i,
  mem_access_ctrl_if.slave bus,
  input  logic             err_clr_i,
  output logic [7:0]       mem_address_o,
  output logic [7:0]       mem_data_in_o,
  output logic             mem_write_enable_o,
  input  logic [7:0]       mem_data_out_i,
  output logic [7:0]       sp_o,
  output logic             stack_ovf_o,
  output logic             stack_unf_o
);

  state_e     state_q;
  op_e        op_q;
  logic [7:0] addr_q, data_q, pc_q;
  logic       ready_q;
  logic       resp_valid_q, resp_err_q, pc_load_q;
  logic [7:0] resp_data_q, pc_target_q;

  op_e  req_op;
  logic accept, req_push, req_pop;
  logic full, empty;
  logic reject_full, reject_empty, reject;
  logic sp_inc, sp_dec;

  assign req_op       = op_e'(bus.req_op);
  assign accept       = bus.req_valid & ready_q & ~reset_i;
  assign req_push     = op_is_stack(req_op) & op_writes_mem(req_op);
  assign req_pop      = op_is_stack(req_op) & ~op_writes_mem(req_op);
  assign reject_full  = accept & req_push & full;
  assign reject_empty = accept & req_pop & empty;
  assign reject       = reject_full | reject_empty | (accept & (req_op == OP_RSVD));

  // POP/RET pre-increment at accept; PUSH/CALL post-decrement after the ACCESS write.
  assign sp_inc = accept & req_pop & ~empty;
  assign sp_dec = (state_q == ST_ACCESS) & op_is_stack(op_q) & op_writes_mem(op_q);

  mem_access_ctrl_sp_unit #(
    .SP_INIT     (SP_INIT),
    .STACK_LIMIT (STACK_LIMIT)
  ) u_sp_unit (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc_i   (sp_inc),
    .dec_i   (sp_dec),
    .sp_o    (sp_o),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b1;
      op_q         <= OP_NOP;
      addr_q       <= 8'h00;
      data_q       <= 8'h00;
      pc_q         <= 8'h00;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      pc_load_q    <= 1'b0;
      resp_data_q  <= 8'h00;
      pc_target_q  <= 8'h00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q    <= req_op;
            addr_q  <= bus.req_addr;
            data_q  <= bus.req_data;
            pc_q    <= bus.req_pc;
            ready_q <= 1'b0;
            if (reject) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else begin
              state_q <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          state_q      <= ST_RESP;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          if (op_reads_mem(op_q)) begin
            resp_data_q <= mem_data_out_i;
          end
          if (op_q == OP_CALL) begin
            pc_load_q   <= 1'b1;
            pc_target_q <= addr_q;
          end else if (op_q == OP_RET) begin
            pc_load_q   <= 1'b1;
            pc_target_q <= mem_data_out_i;
          end
        end
        ST_RESP: begin
          state_q      <= ST_IDLE;
          ready_q      <= 1'b1;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          pc_load_q    <= 1'b0;
          resp_data_q  <= 8'h00;
          pc_target_q  <= 8'h00;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Write enable is gated by reset so an aborted ACCESS never reaches the memory.
  always_comb begin
    mem_address_o      = sp_o;
    mem_data_in_o      = 8'h00;
    mem_write_enable_o = 1'b0;
    if (state_q == ST_ACCESS) begin
      if ((op_q == OP_LOAD) || (op_q == OP_STORE)) begin
        mem_address_o = addr_q;
      end
      if (op_writes_mem(op_q)) begin
        mem_write_enable_o = ~reset_i;
        mem_data_in_o      = (op_q == OP_CALL) ? pc_q : data_q;
      end
    end
  end

`ifdef STACK_CHECK_EN
  logic ovf_q, unf_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (reject_full) begin
        ovf_q <= 1'b1;
      end else if (err_clr_i) begin
        ovf_q <= 1'b0;
      end
      if (reject_empty) begin
        unf_q <= 1'b1;
      end else if (err_clr_i) begin
        unf_q <= 1'b0;
      end
    end
  end

  assign stack_ovf_o = ovf_q;
  assign stack_unf_o = unf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr_i;
  assign stack_ovf_o    = 1'b0;
  assign stack_unf_o    = 1'b0;
`endif

  assign bus.req_ready  = ready_q & ~reset_i;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.pc_load    = pc_load_q;
  assign bus.pc_target  = pc_target_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed, table-driven bench for mem_access_ctrl with a behavioural 256x8 memory model.
module tb_mem_access_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       err_clr = 1'b0;
  logic       tb_mem_clr = 1'b1;
  logic [7:0] mem_addr, mem_din, mem_dout, sp;
  logic       mem_we, ovf, unf;

  int checks = 0;
  int errors = 0;

  mem_access_ctrl_if bus ();

  mem_access_ctrl dut (
    .clk_i              (clk),
    .reset_i            (reset),
    .bus                (bus),
    .err_clr_i          (err_clr),
    .mem_address_o      (mem_addr),
    .mem_data_in_o      (mem_din),
    .mem_write_enable_o (mem_we),
    .mem_data_out_i     (mem_dout),
    .sp_o               (sp),
    .stack_ovf_o        (ovf),
    .stack_unf_o        (unf)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (tb_mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_din;
    end
  end
  assign mem_dout = mem[mem_addr];

  typedef struct {
    logic [2:0] op;
    logic [7:0] addr, data, pc;
    logic [7:0] e_rdata;
    logic       e_err, e_pl;
    logic [7:0] e_pt, e_sp;
    int         e_lat;
    logic       e_we;
    logic [7:0] e_waddr, e_wdata;
    logic       e_ovf, e_unf;
  } vec_t;

  function automatic vec_t mk(logic [2:0] op, logic [7:0] addr, logic [7:0] data, logic [7:0] pc,
                              logic [7:0] e_rdata, logic e_err, logic e_pl, logic [7:0] e_pt,
                              logic [7:0] e_sp, int e_lat, logic e_we, logic [7:0] e_waddr,
                              logic [7:0] e_wdata, logic e_ovf, logic e_unf);
    vec_t v;
    v.op = op; v.addr = addr; v.data = data; v.pc = pc;
    v.e_rdata = e_rdata; v.e_err = e_err; v.e_pl = e_pl; v.e_pt = e_pt; v.e_sp = e_sp;
    v.e_lat = e_lat; v.e_we = e_we; v.e_waddr = e_waddr; v.e_wdata = e_wdata;
    v.e_ovf = e_ovf; v.e_unf = e_unf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " ready"},      bus.req_ready, 1'b1);
    chk({tag, " resp_valid"}, bus.resp_valid, 1'b0);
    chk({tag, " resp_err"},   bus.resp_err, 1'b0);
    chk({tag, " pc_load"},    bus.pc_load, 1'b0);
    chk({tag, " resp_data"},  bus.resp_data, 8'h00);
    chk({tag, " pc_target"},  bus.pc_target, 8'h00);
    chk({tag, " sp"},         sp, 8'hFF);
    chk({tag, " ovf"},        ovf, 1'b0);
    chk({tag, " unf"},        unf, 1'b0);
    chk({tag, " mem_we"},     mem_we, 1'b0);
  endtask

  // Called at/just after a negedge with the DUT idle; returns at the negedge after the response.
  task automatic run_vec(input vec_t v, input int idx);
    int n, lat;
    logic got, saw_we;
    logic [7:0] waddr, wdata, rdata, pt;
    logic err, pl;
    bus.req_valid = 1'b1; bus.req_op = v.op; bus.req_addr = v.addr;
    bus.req_data = v.data; bus.req_pc = v.pc;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 8) begin
      @(negedge clk); n++;
    end
    chk($sformatf("v%0d accepted", idx), (n < 8), 1'b1);
    if (n >= 8) begin
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    lat = 0; got = 1'b0; saw_we = 1'b0; waddr = 8'h00; wdata = 8'h00;
    rdata = 8'h00; pt = 8'h00; err = 1'b0; pl = 1'b0;
    while (!got && lat < 6) begin
      @(negedge clk); lat++;
      if (lat == 1) begin
        bus.req_valid = 1'b0; bus.req_op = 3'd7;
        bus.req_addr = 8'h5A; bus.req_data = 8'hC3; bus.req_pc = 8'h3C;
      end
      if (mem_we === 1'b1) begin
        saw_we = 1'b1; waddr = mem_addr; wdata = mem_din;
      end
      if (bus.resp_valid === 1'b1) begin
        got = 1'b1; rdata = bus.resp_data; err = bus.resp_err;
        pl = bus.pc_load; pt = bus.pc_target;
      end
    end
    chk($sformatf("v%0d latency", idx),   lat, v.e_lat);
    chk($sformatf("v%0d resp_data", idx), rdata, v.e_rdata);
    chk($sformatf("v%0d resp_err", idx),  err, v.e_err);
    chk($sformatf("v%0d pc_load", idx),   pl, v.e_pl);
    chk($sformatf("v%0d pc_target", idx), pt, v.e_pt);
    chk($sformatf("v%0d sp", idx),        sp, v.e_sp);
    chk($sformatf("v%0d mem_we", idx),    saw_we, v.e_we);
    if (v.e_we) begin
      chk($sformatf("v%0d waddr", idx), waddr, v.e_waddr);
      chk($sformatf("v%0d wdata", idx), wdata, v.e_wdata);
    end
    chk($sformatf("v%0d ovf", idx), ovf, v.e_ovf);
    chk($sformatf("v%0d unf", idx), unf, v.e_unf);
    @(negedge clk);
    chk($sformatf("v%0d pulse", idx), bus.resp_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    int npulse;

    bus.req_valid = 1'b0; bus.req_op = 3'd0; bus.req_addr = 8'h00;
    bus.req_data = 8'h00; bus.req_pc = 8'h00;

    //        op    addr   data   pc     rdata  err pl pt     sp     lat we waddr  wdata  ovf unf
    tbl.push_back(mk(3'd2, 8'h10, 8'hA5, 8'h00, 8'h00, 0, 0, 8'h00, 8'hFF, 2, 1, 8'h10, 8'hA5, 0, 0));
    tbl.push_back(mk(3'd1, 8'h10, 8'h00, 8'h00, 8'hA5, 0, 0, 8'h00, 8'hFF, 2, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk(3'd3, 8'h00, 8'h11, 8'h00, 8'h00, 0, 0, 8'h00, 8'hFE, 2, 1, 8'hFF, 8'h11, 0, 0));
    tbl.push_back(mk(3'd3, 8'h00, 8'h22, 8'h00, 8'h00, 0, 0, 8'h00, 8'hFD, 2, 1, 8'hFE, 8'h22, 0, 0));
    tbl.push_back(mk(3'd4, 8'h00, 8'h00, 8'h00, 8'h22, 0, 0, 8'h00, 8'hFE, 2, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk(3'd4, 8'h00, 8'h00, 8'h00, 8'h11, 0, 0, 8'h00, 8'hFF, 2, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk(3'd5, 8'h40, 8'h00, 8'h07, 8'h00, 0, 1, 8'h40, 8'hFE, 2, 1, 8'hFF, 8'h07, 0, 0));
    tbl.push_back(mk(3'd6, 8'h00, 8'h00, 8'h00, 8'h07, 0, 1, 8'h07, 8'hFF, 2, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk(3'd0, 8'h33, 8'h44, 8'h55, 8'h00, 0, 0, 8'h00, 8'hFF, 2, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk(3'd7, 8'h12, 8'h34, 8'h56, 8'h00, 1, 0, 8'h00, 8'hFF, 1, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk(3'd2, 8'h00, 8'h3C, 8'h00, 8'h00, 0, 0, 8'h00, 8'hFF, 2, 1, 8'h00, 8'h3C, 0, 0));
    tbl.push_back(mk(3'd1, 8'h00, 8'h00, 8'h00, 8'h3C, 0, 0, 8'h00, 8'hFF, 2, 0, 8'h00, 8'h00, 0, 0));
`ifdef STACK_CHECK_EN
    tbl.push_back(mk(3'd4, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 8'hFF, 1, 0, 8'h00, 8'h00, 0, 1));
`else
    tbl.push_back(mk(3'd4, 8'h00, 8'h00, 8'h00, 8'h3C, 0, 0, 8'h00, 8'h00, 2, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk(3'd3, 8'h00, 8'h5A, 8'h00, 8'h00, 0, 0, 8'h00, 8'hFF, 2, 1, 8'h00, 8'h5A, 0, 0));
`endif

    @(negedge clk);
    chk("reset ready low", bus.req_ready, 1'b0);
    @(negedge clk);
    reset = 1'b0; tb_mem_clr = 1'b0;
    #1;
    chk_reset_state("por");

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

`ifdef STACK_CHECK_EN
    for (int i = 0; i < 32; i++)
      run_vec(mk(3'd3, 8'h00, 8'(i + 1), 8'h00, 8'h00, 0, 0, 8'h00, 8'(8'hFE - i), 2, 1,
                 8'(8'hFF - i), 8'(i + 1), 0, 1), 100 + i);
    run_vec(mk(3'd3, 8'h00, 8'hEE, 8'h00, 8'h00, 1, 0, 8'h00, 8'hDF, 1, 0, 8'h00, 8'h00, 1, 1), 200);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr ovf", ovf, 1'b0);
    chk("err_clr unf", unf, 1'b0);
`endif

    reset = 1'b1;
    #1;
    chk("rst ready low", bus.req_ready, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_reset_state("rst");

    run_vec(mk(3'd3, 8'h00, 8'h99, 8'h00, 8'h00, 0, 0, 8'h00, 8'hFE, 2, 1, 8'hFF, 8'h99, 0, 0), 300);
    bus.req_valid = 1'b1; bus.req_op = 3'd2; bus.req_addr = 8'h20; bus.req_data = 8'h77;
    chk("abort ready", bus.req_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("abort access we", mem_we, 1'b1);
    reset = 1'b1;
    #1;
    chk("abort we gated", mem_we, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort resp_valid", bus.resp_valid, 1'b0);
    chk("abort sp", sp, 8'hFF);
    chk("abort ready after", bus.req_ready, 1'b1);
    @(negedge clk);
    chk("abort no late resp", bus.resp_valid, 1'b0);
    chk("abort mem untouched", mem[8'h20], 8'h00);

    npulse = 0;
    bus.req_valid = 1'b1; bus.req_op = 3'd1; bus.req_addr = 8'h10;
    for (int c = 0; c < 12; c++) begin
      chk($sformatf("b2b ready c%0d", c), bus.req_ready, ((c % 3) == 0));
      if (bus.resp_valid === 1'b1) begin
        npulse++;
        chk($sformatf("b2b data c%0d", c), bus.resp_data, 8'hA5);
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    chk("b2b pulses", npulse, 4);

    run_vec(mk(3'd7, 8'h40, 8'h00, 8'h07, 8'h00, 1, 0, 8'h00, 8'hFF, 1, 0, 8'h00, 8'h00, 0, 0), 400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
